// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> M-extension sequencer handshake bundle.
// master: the Execute stage (drives the operation), slave: ex_muldiv_ctrl.
interface ex_muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [4:0]      ALUControlE;
  logic [XLEN-1:0] src_a_i;
  logic [XLEN-1:0] src_b_i;
  logic [4:0]      rd_i;
  logic            kill_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, ALUControlE, src_a_i, src_b_i, rd_i, kill_i,
    input  stall_o, busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, ALUControlE, src_a_i, src_b_i, rd_i, kill_i,
    output stall_o, busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MUL/DIV sequencer for the Execute stage. Stalls the front of the
// pipeline while a pipelined multiply or a restoring divide runs, then presents
// the result for exactly one cycle so EX/MEM captures it instead of the ALU output.
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_ctrl_if.slave md
);

  localparam logic [4:0] OpMul    = 5'b01010;
  localparam logic [4:0] OpMulh   = 5'b01011;
  localparam logic [4:0] OpMulhsu = 5'b01100;
  localparam logic [4:0] OpDiv    = 5'b01110;
  localparam logic [4:0] OpRem    = 5'b10000;
  localparam logic [4:0] OpRemu   = 5'b10001;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  // Decode of the instruction currently in EX
  logic            is_md, accept, in_div, in_rem, in_sdiv, in_b_zero, in_ovf;
  logic            sign_a, sign_b;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b, spec_res;
  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;

  // Latched operation state
  logic [4:0]      op_q, rd_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            neg_q_q, neg_r_q;
  logic [2*XLEN-1:0] pipe_q [MUL_LAT];

  // Divider step and final result selection
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fix, rem_fix, div_res, mul_res;
  logic            fin_mul, fin_div, fin_spec;

  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;
  logic            done_q;

  // Operation decode, special-case detection and multiplier input extension
  always_comb begin
    is_md     = (md.ALUControlE >= OpMul) && (md.ALUControlE <= OpRemu);
    // Nothing may be accepted while reset is held, so stall_o stays low too.
    accept    = rst && (state_q == StIdle) && md.start_i && is_md && !md.kill_i;
    in_div    = md.ALUControlE >= OpDiv;
    in_rem    = md.ALUControlE >= OpRem;
    in_sdiv   = (md.ALUControlE == OpDiv) || (md.ALUControlE == OpRem);
    in_b_zero = md.src_b_i == '0;
    in_ovf    = in_sdiv && (md.src_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (md.src_b_i == '1);
    if (in_b_zero) begin
      spec_res = in_rem ? md.src_a_i : '1;
    end else begin
      spec_res = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    a_neg = in_sdiv && md.src_a_i[XLEN-1];
    b_neg = in_sdiv && md.src_b_i[XLEN-1];
    abs_a = a_neg ? (~md.src_a_i + 1'b1) : md.src_a_i;
    abs_b = b_neg ? (~md.src_b_i + 1'b1) : md.src_b_i;

    sign_a = (md.ALUControlE == OpMul) || (md.ALUControlE == OpMulh) ||
             (md.ALUControlE == OpMulhsu);
    sign_b = (md.ALUControlE == OpMul) || (md.ALUControlE == OpMulh);
    mul_a  = {sign_a & md.src_a_i[XLEN-1], md.src_a_i};
    mul_b  = {sign_b & md.src_b_i[XLEN-1], md.src_b_i};
    prod   = mul_a * mul_b;
  end

  // One restoring-divide step plus sign fix-up of the final quotient/remainder
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dvs_q};
    rem_nx  = ge ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
    quo_fix = neg_q_q ? (~quo_nx + 1'b1) : quo_nx;
    rem_fix = neg_r_q ? (~rem_nx + 1'b1) : rem_nx;
    div_res = (op_q >= OpRem) ? rem_fix : quo_fix;
    mul_res = (op_q == OpMul) ? pipe_q[MUL_LAT-1][XLEN-1:0]
                              : pipe_q[MUL_LAT-1][2*XLEN-1:XLEN];
  end

  // FSM state and iteration counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; kill overrides everything and drops the op silently
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fin_mul  = 1'b0;
    fin_div  = 1'b0;
    fin_spec = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!in_div) begin
            state_d = StMul;
            cnt_d   = 5'(MUL_LAT - 1);
          end else if (in_b_zero || in_ovf) begin
            state_d  = StDone;
            fin_spec = 1'b1;
          end else begin
            state_d = StDiv;
            cnt_d   = 5'(XLEN - 1);
          end
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          fin_mul = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          fin_div = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (md.kill_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      fin_mul = 1'b0;
      fin_div = 1'b0;
    end
  end

  // Operand latch, divider iteration and multiplier pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      for (int k = 0; k < int'(MUL_LAT); k++) pipe_q[k] <= '0;
    end else begin
      if (accept) begin
        op_q      <= md.ALUControlE;
        rd_q      <= md.rd_i;
        quo_q     <= abs_a;
        rem_q     <= '0;
        dvs_q     <= abs_b;
        neg_q_q   <= a_neg ^ b_neg;
        neg_r_q   <= a_neg;
        pipe_q[0] <= prod;
      end else if (state_q == StDiv) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
      end
      for (int k = 1; k < int'(MUL_LAT); k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  // Registered result; held until the next completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= state_d == StDone;
      if (fin_spec) begin
        result_q <= spec_res;
        rd_out_q <= md.rd_i;
      end else if (fin_mul) begin
        result_q <= mul_res;
        rd_out_q <= rd_q;
      end else if (fin_div) begin
        result_q <= div_res;
        rd_out_q <= rd_q;
      end
    end
  end

  assign md.stall_o  = !md.kill_i && (accept || (state_q == StMul) || (state_q == StDiv));
  assign md.busy_o   = state_q != StIdle;
  assign md.done_o   = done_q;
  assign md.result_o = result_q;
  assign md.rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl: directed cases, randomized ops against
// an arithmetic reference model, kill, back-to-back and asynchronous reset.
module tb_ex_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_DIVU   = 5'b01111;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  ex_muldiv_ctrl_if #(.XLEN(32)) bus ();

  ex_muldiv_ctrl #(.XLEN(32), .MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result computed directly from the RISC-V M-extension rules.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      OP_REMU: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  // Cycle index (accept cycle = 0) in which done_o must be seen.
  function automatic int done_cycle(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < OP_DIV) return MUL_LAT + 1;
    if (b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    bus.start_i     = 1'b1;
    bus.kill_i      = 1'b0;
    bus.ALUControlE = op;
    bus.src_a_i     = a;
    bus.src_b_i     = b;
    bus.rd_i        = rd;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.start_i     = 1'b0;
    bus.kill_i      = 1'b0;
    bus.ALUControlE = 5'b00000;
  endtask

  // Observes an op from its accept cycle until done_o, within a fixed budget.
  task automatic watch_op(input string name, input logic [31:0] exp_res,
                          input logic [4:0] exp_rd, input int exp_done);
    int done_cyc = -1;
    int stalls = 0;
    int busies = 0;
    logic [31:0] res = '0;
    logic [4:0] rdv = '0;
    for (int c = 0; c <= exp_done + 2; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus.stall_o) stalls++;
      if (bus.busy_o) busies++;
      if (bus.done_o) begin
        done_cyc = c;
        res = bus.result_o;
        rdv = bus.rd_o;
        break;
      end
    end
    total++;
    if (done_cyc !== exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    total++;
    if (stalls !== exp_done) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, exp_done);
    end
    total++;
    if (busies !== exp_done) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busies, exp_done);
    end
    total++;
    if (res !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    end
    total++;
    if (rdv !== exp_rd) begin
      bad++;
      $display("FAIL %s rd: got %0d expected %0d", name, rdv, exp_rd);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp_res);
    @(negedge clk);
    drive_op(op, a, b, rd);
    watch_op(name, exp_res, rd, done_cycle(op, a, b));
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if ({bus.stall_o, bus.busy_o, bus.done_o} !== 3'b000) begin
      bad++;
      $display("FAIL %s flags: stall/busy/done got %b expected 000", name,
               {bus.stall_o, bus.busy_o, bus.done_o});
    end
    total++;
    if (bus.result_o !== 32'h0) begin
      bad++;
      $display("FAIL %s result: got %h expected 00000000", name, bus.result_o);
    end
    total++;
    if (bus.rd_o !== 5'd0) begin
      bad++;
      $display("FAIL %s rd: got %0d expected 0", name, bus.rd_o);
    end
  endtask

  task automatic test_reset();
    #3;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul();
    run_op("mul_7_x_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
    run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
    run_op("mulh_min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000);
    run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF);
    idle();
  endtask

  task automatic test_div();
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd10, 32'd2);
    idle();
  endtask

  task automatic test_special();
    run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
    run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd12, 32'd5);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0);
    idle();
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    for (int i = 0; i < 40; i++) begin
      op = OP_MUL + 5'($urandom_range(0, 7));
      a  = rnd_operand();
      b  = rnd_operand();
      rd = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, rd, model(op, a, b));
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", OP_DIVU, 32'd1000, 32'd9, 5'd20, model(OP_DIVU, 32'd1000, 32'd9));
    run_op("b2b_second", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21,
           model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
    idle();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (bus.result_o !== model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0) || bus.rd_o !== 5'd21) begin
      bad++;
      $display("FAIL b2b_hold: got result %h rd %0d expected %h rd 21", bus.result_o, bus.rd_o,
               model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));
    end
    total++;
    if (bus.done_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_no_redone: got done_o %b expected 0", bus.done_o);
    end
  endtask

  task automatic test_kill();
    int dones = 0;
    @(negedge clk);
    drive_op(OP_DIV, 32'd12345, 32'd7, 5'd17);
    #1;
    if (bus.done_o) dones++;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) bus.kill_i = 1'b1;
      #1;
      if (bus.done_o) dones++;
    end
    total++;
    if (bus.stall_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_stall: got stall_o %b expected 0", bus.stall_o);
    end
    @(negedge clk);
    drive_op(OP_MUL, 32'd6, 32'd9, 5'd18);
    #1;
    if (bus.done_o) dones++;
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_busy: got busy_o %b expected 0", bus.busy_o);
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL kill_no_done: got %0d done pulses expected 0", dones);
    end
    watch_op("kill_then_mul", 32'd54, 5'd18, MUL_LAT + 1);
    idle();
  endtask

  task automatic test_async_reset();
    int flags = 0;
    @(negedge clk);
    drive_op(OP_DIV, 32'd1000, 32'd3, 5'd25);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    bus.ALUControlE = 5'b00000;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.ALUControlE = 5'($urandom_range(0, 9));
      #1;
      if (bus.stall_o || bus.done_o || bus.busy_o) flags++;
      @(negedge clk);
      bus.ALUControlE = 5'($urandom_range(18, 31));
      #1;
      if (bus.stall_o || bus.done_o || bus.busy_o) flags++;
      @(negedge clk);
    end
    total++;
    if (flags !== 0) begin
      bad++;
      $display("FAIL non_m_after_reset: got %0d cycles with stall/busy/done expected 0", flags);
    end
    idle();
    run_op("after_reset_rem", OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd26,
           model(OP_REM, 32'hFFFF_FF9C, 32'd7));
    idle();
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.kill_i      = 1'b0;
    bus.ALUControlE = 5'b00000;
    bus.src_a_i     = '0;
    bus.src_b_i     = '0;
    bus.rd_i        = '0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_back_to_back();
    test_kill();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
# ex_muldiv_ctrl

Multi-cycle M-extension sequencer attached to the Execute stage. It detects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operations in EX and latches their operands. It holds the front of the pipeline with a stall while it computes the result (pipelined multiply, iterative restoring divide), then presents the result for exactly one cycle so the EX/MEM register captures it in place of the single-cycle ALU output. It replaces the ad-hoc multiply bypass register path in the Execute stage.

## Interface
- XLEN, 32: operand/result width. Only 32 is supported.
- MUL_LAT, 2: multiplier pipeline depth in cycles, 1..4.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  instruction valid in EX, not bubbled.
- ALUControlE  input  5  op code:
  - MUL=01010, MULH=01011, MULHSU=01100, MULHU=01101
  - DIV=01110, DIVU=01111, REM=10000, REMU=10001
  - any other code is not an M op.
- src_a_i  input  XLEN  forwarded rs1 value.
- src_b_i  input  XLEN  forwarded rs2 value.
- rd_i  input  5  destination register.
- kill_i  input  1  flush of the EX instruction.
- stall_o  output  1  hold IF/ID/EX and insert a bubble toward MEM.
- busy_o  output  1  FSM not in IDLE.
- done_o  output  1  result valid this cycle.
- result_o  output  XLEN  M-op result.
- rd_o  output  5  destination register of the result.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE.
- is_md = ALUControlE in 01010..10001.
- accept = (state==IDLE) & start_i & is_md & !kill_i.
- In IDLE, accept latches src_a_i, src_b_i, op and rd_i.
- Transitions out of IDLE on accept:
  - multiply: go to MUL with cnt=MUL_LAT-1.
  - divide with src_b==0: go directly to DONE.
  - DIV/REM with src_a=0x80000000 and src_b=0xFFFFFFFF: go directly to DONE.
  - any other divide: go to DIV with cnt=31.
- MUL state:
  - Multiplier computes a 33x33 signed product of sign/zero-extended operands. MUL/MULH sign-extend both operands; MULHSU sign-extends a and zero-extends b; MULHU zero-extends both.
  - The product passes through MUL_LAT register stages.
  - cnt==0 → DONE, else cnt−1.
  - MUL selects product[31:0]; all other multiply ops select product[63:32].
- DIV state:
  - Restoring divide, one quotient bit per cycle, on magnitudes (signed ops take absolute values at accept).
  - cnt==0 → DONE, else cnt−1.
  - Sign fix-up in DONE: quotient is negated when operand signs differ (signed ops only); remainder takes the dividend's sign.
- Special results:
  - x/0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Overflow (0x80000000 / −1): DIV gives 0x80000000; REM gives 0.
- DONE: done_o=1, stall_o=0, result_o and rd_o valid. Next state is IDLE unconditionally. The same held instruction still shows start_i, but it is not re-accepted.
- stall_o = accept | (state∈{MUL,DIV}), forced 0 when kill_i=1.
- kill_i in any state: next state IDLE, the counter is cleared, and done_o is never raised for the killed op.
- start_i with a non-M op in IDLE: ignored, stall_o=0.

## Timing
- Reset values: state=IDLE, stall_o=0, busy_o=0, done_o=0, result_o=0, rd_o=0, cnt=0.
- done_o, result_o and rd_o are registered.
- result_o and rd_o hold their values after DONE until the next DONE.
- EX occupancy including the accept cycle:
  - multiply: MUL_LAT+2 cycles (4 at default), i.e. MUL_LAT+1 stall cycles, then DONE.
  - normal divide: 34 cycles (33 stall cycles + DONE).
  - divide-by-zero or overflow: 2 cycles (1 stall cycle + DONE).
- stall_o is combinational from state, start_i, ALUControlE and kill_i. It must settle within the same cycle as accept.
- Back-to-back M ops: the next op is accepted the cycle after DONE (IDLE). There is no zero-gap issue.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous) and the in-flight op is discarded.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), MUL_LAT=2 → stall_o high for cycles 0–2; done_o in cycle 3; result_o=0xFFFFFFEB; rd_o=latched rd.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD with done_o at cycle 33. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. Each completes with done_o at cycle 1.
- kill_i at cycle 10 of a DIV → stall_o=0 that cycle; busy_o=0 next cycle; no done_o. A MUL presented the following cycle is accepted normally.
- rst pulled low at cycle 5 of a DIV → all outputs 0 asynchronously. After release, a non-M op with start_i=1 keeps stall_o=0 and done_o=0.
